// File: rtl/segcapture_if.sv
// Bus bundle for segcapture: serial segment lanes and shift clock in, decoded BCD value and status pulses out.
interface segcapture_if #(
    parameter int DIGITS = 6
);
    logic [DIGITS-1:0]   segIn;
    logic                shiftIn;
    logic [4*DIGITS-1:0] cnt_out;
    logic                valid;
    logic                codeErr;
    logic                frameErr;

    modport master (
        output segIn,
        output shiftIn,
        input  cnt_out,
        input  valid,
        input  codeErr,
        input  frameErr
    );

    modport slave (
        input  segIn,
        input  shiftIn,
        output cnt_out,
        output valid,
        output codeErr,
        output frameErr
    );
endinterface

// File: rtl/segcapture.sv
// Captures DIGITS serial 7-segment frames (8 bits LSB first per lane) and decodes them to BCD.
// Optional idle-timeout in RECV is enabled by defining SEGCAPTURE_TIMEOUT_EN.
module segcapture #(
    parameter int DIGITS  = 6,
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    segcapture_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RECV, DECODE, DONE} state_t;

    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Returns {error, nibble}; anything outside the ten legal glyphs (including bit7 set) is an error.
    function automatic logic [4:0] decode_seg(input logic [7:0] pat);
        logic [4:0] res;
        case (pat)
            8'h3F:   res = 5'h00;
            8'h06:   res = 5'h01;
            8'h5B:   res = 5'h02;
            8'h4F:   res = 5'h03;
            8'h66:   res = 5'h04;
            8'h6D:   res = 5'h05;
            8'h7D:   res = 5'h06;
            8'h07:   res = 5'h07;
            8'h7F:   res = 5'h08;
            8'h6F:   res = 5'h09;
            default: res = 5'h1F;
        endcase
        return res;
    endfunction

    logic [DIGITS-1:0]   seg_s1_q, seg_s2_q;
    logic                shift_s1_q, shift_s2_q, shift_s3_q;
    logic                edge_s;
    logic [4:0]          dec_s;

    state_t              state_q, state_d;
    logic [2:0]          bit_q, bit_d;
    logic [DW-1:0]       dig_q, dig_d;
    logic [7:0]          frame_q [DIGITS];
    logic [7:0]          frame_d [DIGITS];
    logic [4*DIGITS-1:0] result_q, result_d;
    logic                err_q, err_d;
    logic [4*DIGITS-1:0] cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic                code_err_q, code_err_d;
    logic                frame_err_q, frame_err_d;

`ifdef SEGCAPTURE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]       idle_q, idle_d;
`endif

    // Two-flop synchronizers; the third shift flop only serves edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_s1_q   <= '0;
            seg_s2_q   <= '0;
            shift_s1_q <= 1'b0;
            shift_s2_q <= 1'b0;
            shift_s3_q <= 1'b0;
        end else begin
            seg_s1_q   <= bus.segIn;
            seg_s2_q   <= seg_s1_q;
            shift_s1_q <= bus.shiftIn;
            shift_s2_q <= shift_s1_q;
            shift_s3_q <= shift_s2_q;
        end
    end

    assign edge_s = shift_s2_q & ~shift_s3_q;
    assign dec_s  = decode_seg(frame_q[dig_q]);

    // Next-state, capture and decode logic.
    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        dig_d       = dig_q;
        frame_d     = frame_q;
        result_d    = result_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        valid_d     = 1'b0;
        code_err_d  = 1'b0;
        frame_err_d = 1'b0;
`ifdef SEGCAPTURE_TIMEOUT_EN
        idle_d      = '0;
`endif
        case (state_q)
            IDLE: begin
                if (edge_s) begin
                    for (int d = 0; d < DIGITS; d++) begin
                        frame_d[d][bit_q] = seg_s2_q[d];
                    end
                    bit_d   = 3'd1;
                    state_d = RECV;
                end else begin
                    bit_d = 3'd0;
                end
            end
            RECV: begin
                if (edge_s) begin
                    for (int d = 0; d < DIGITS; d++) begin
                        frame_d[d][bit_q] = seg_s2_q[d];
                    end
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
                        dig_d   = '0;
                        err_d   = 1'b0;
                        state_d = DECODE;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
`ifdef SEGCAPTURE_TIMEOUT_EN
                    if (idle_q == TW'(TIMEOUT - 1)) begin
                        // Abandon the partial frame so the next edge starts cleanly at bit 0.
                        for (int d = 0; d < DIGITS; d++) begin
                            frame_d[d] = 8'h00;
                        end
                        bit_d       = 3'd0;
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        idle_d = idle_q + TW'(1);
                    end
`else
                    bit_d = bit_q;
`endif
                end
            end
            DECODE: begin
                frame_err_d = edge_s;
                for (int d = 0; d < DIGITS; d++) begin
                    if (dig_q == DW'(d)) begin
                        result_d[4*d +: 4] = dec_s[3:0];
                    end else begin
                        result_d[4*d +: 4] = result_q[4*d +: 4];
                    end
                end
                err_d = err_q | dec_s[4];
                if (dig_q == DW'(DIGITS - 1)) begin
                    // Outputs are registered here so they appear for exactly the DONE cycle.
                    cnt_d      = result_d;
                    valid_d    = 1'b1;
                    code_err_d = err_d;
                    state_d    = DONE;
                end else begin
                    dig_d = dig_q + DW'(1);
                end
            end
            DONE: begin
                frame_err_d = edge_s;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_q       <= 3'd0;
            dig_q       <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            code_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
            for (int d = 0; d < DIGITS; d++) begin
                frame_q[d] <= 8'h00;
            end
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            dig_q       <= dig_d;
            result_q    <= result_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            code_err_q  <= code_err_d;
            frame_err_q <= frame_err_d;
            for (int d = 0; d < DIGITS; d++) begin
                frame_q[d] <= frame_d[d];
            end
        end
    end

`ifdef SEGCAPTURE_TIMEOUT_EN
    // Idle-clock counter for the RECV timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`endif

    assign bus.cnt_out  = cnt_q;
    assign bus.valid    = valid_q;
    assign bus.codeErr  = code_err_q;
    assign bus.frameErr = frame_err_q;
endmodule

// File: tb/tb_segcapture.sv
// Table-driven, scoreboard-based bench for segcapture (DIGITS=6); also covers reset, overrun and timeout.
module tb_segcapture;
    logic clk;
    logic reset;

    segcapture_if #(.DIGITS(6)) bus ();

    segcapture #(.DIGITS(6), .TIMEOUT(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] cnt;
        logic        err;
    } exp_t;

    typedef struct {
        logic [23:0] digs;
        int          bad_lane;
        logic [7:0]  bad_byte;
        logic [23:0] exp_cnt;
        logic        exp_err;
    } vec_t;

    localparam logic [7:0] SEG_TBL [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                            8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    exp_t sb_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   fe_cnt    = 0;
    int   valid_cnt = 0;
    int   pushed    = 0;
    int   last_valid_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [47:0] enc(input logic [23:0] digs);
        logic [47:0] f;
        f = '0;
        for (int d = 0; d < 6; d++) f[8*d +: 8] = SEG_TBL[digs[4*d +: 4]];
        return f;
    endfunction

    // Output monitor: scoreboard pops on valid, counts frameErr pulses.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.frameErr) fe_cnt++;
            if (bus.valid) begin
                valid_cnt++;
                last_valid_cyc = cyc;
                if (sb_q.size() == 0) begin
                    chk("unexpected_valid", {8'h00, bus.cnt_out}, 32'hDEADBEEF);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("cnt_out", {8'h00, bus.cnt_out}, {8'h00, e.cnt});
                    chk("codeErr", {31'd0, bus.codeErr}, {31'd0, e.err});
                end
            end else begin
                chk("codeErr_idle", {31'd0, bus.codeErr}, 32'd0);
            end
        end
    end

    task automatic send_bit(input logic [47:0] f, input int k);
        @(posedge clk); #1;
        for (int d = 0; d < 6; d++) bus.segIn[d] = f[8*d + k];
        bus.shiftIn = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.shiftIn = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.shiftIn = 1'b0;
    endtask

    task automatic send_bits(input logic [47:0] f, input int lo, input int hi);
        for (int k = lo; k <= hi; k++) send_bit(f, k);
    endtask

    task automatic push_exp(input logic [23:0] c, input logic e);
        exp_t x;
        x.cnt = c;
        x.err = e;
        sb_q.push_back(x);
        pushed++;
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 40 && sb_q.size() != 0; n++) @(posedge clk);
        repeat (2) @(posedge clk);
        chk(name, sb_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [8];
        logic [47:0] f;
        logic [23:0] prev;
        int          fe0, v0, c0;

        vecs[0] = '{24'h123456, -1, 8'h00, 24'h123456, 1'b0};
        vecs[1] = '{24'h123456,  2, 8'h49, 24'h123F56, 1'b1};
        vecs[2] = '{24'h000000, -1, 8'h00, 24'h000000, 1'b0};
        vecs[3] = '{24'h987654, -1, 8'h00, 24'h987654, 1'b0};
        vecs[4] = '{24'h111111, -1, 8'h00, 24'h111111, 1'b0};
        vecs[5] = '{24'h222222, -1, 8'h00, 24'h222222, 1'b0};
        vecs[6] = '{24'h987654,  0, 8'h86, 24'h98765F, 1'b1};
        vecs[7] = '{24'h190909,  5, 8'h00, 24'hF90909, 1'b1};

        reset = 1'b1;
        bus.segIn = '0;
        bus.shiftIn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cnt_out",  {8'h00, bus.cnt_out}, 32'd0);
        chk("rst_valid",    {31'd0, bus.valid},    32'd0);
        chk("rst_codeErr",  {31'd0, bus.codeErr},  32'd0);
        chk("rst_frameErr", {31'd0, bus.frameErr}, 32'd0);
        reset = 1'b0;
        repeat (3) @(posedge clk);

        // Table of frames; cnt_out must hold the previous value until the last edge.
        prev = 24'h000000;
        for (int i = 0; i < 8; i++) begin
            f = enc(vecs[i].digs);
            if (vecs[i].bad_lane >= 0) f[8*vecs[i].bad_lane +: 8] = vecs[i].bad_byte;
            push_exp(vecs[i].exp_cnt, vecs[i].exp_err);
            send_bits(f, 0, 6);
            chk("hold_cnt_out", {8'h00, bus.cnt_out}, {8'h00, prev});
            send_bits(f, 7, 7);
            drain("table_drain");
            prev = vecs[i].exp_cnt;
        end

        // Overrun: extra edge right behind the 8th; also measures latency.
        fe0 = fe_cnt;
        v0  = valid_cnt;
        f   = enc(24'h314159);
        push_exp(24'h314159, 1'b0);
        send_bits(f, 0, 6);
        @(posedge clk); #1;
        for (int d = 0; d < 6; d++) bus.segIn[d] = f[8*d + 7];
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.shiftIn = 1'b1;
        c0 = cyc;
        @(posedge clk); #1;
        bus.shiftIn = 1'b0;
        @(posedge clk); #1;
        bus.shiftIn = 1'b1;
        @(posedge clk); #1;
        bus.shiftIn = 1'b0;
        for (int n = 0; n < 20 && valid_cnt == v0; n++) @(posedge clk);
        @(negedge clk);
        chk("ovr_valid_seen", valid_cnt - v0, 32'd1);
        chk("ovr_latency", last_valid_cyc - c0, 32'd9);
        chk("ovr_frameErr", fe_cnt - fe0, 32'd1);
        drain("ovr_drain");

        // Reset mid-frame clears outputs immediately; the next frame decodes normally.
        f = enc(24'h987654);
        send_bits(f, 0, 3);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_cnt_out",  {8'h00, bus.cnt_out}, 32'd0);
        chk("mid_rst_valid",    {31'd0, bus.valid},    32'd0);
        chk("mid_rst_codeErr",  {31'd0, bus.codeErr},  32'd0);
        chk("mid_rst_frameErr", {31'd0, bus.frameErr}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        push_exp(24'h987654, 1'b0);
        send_bits(f, 0, 7);
        drain("post_rst_drain");

        // Stalled partial frame.
        fe0 = fe_cnt;
        v0  = valid_cnt;
        f   = enc(24'h000000);
        send_bits(f, 0, 2);
        repeat (80) @(posedge clk);
        @(negedge clk);
        chk("stall_no_valid", valid_cnt - v0, 32'd0);
`ifdef SEGCAPTURE_TIMEOUT_EN
        chk("timeout_frameErr", fe_cnt - fe0, 32'd1);
`else
        chk("stall_no_frameErr", fe_cnt - fe0, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
`endif
        push_exp(24'h000000, 1'b0);
        send_bits(f, 0, 7);
        drain("stall_next_drain");

        repeat (5) @(posedge clk);
        chk("valid_total", valid_cnt, pushed);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/segcapture.md
SEGCAPTURE -- requirements
Module: segcapture

Interface
REQ-001: Parameter DIGITS, default 6, SHALL set the number of serial segment lanes and BCD digits.
REQ-002: Parameter TIMEOUT, default 64, SHALL set the idle-clock limit used when SEGCAPTURE_TIMEOUT_EN is defined.
REQ-003: clk  input  1  SHALL be the system clock; all state SHALL update on its rising edge.
REQ-004: reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005: segIn  input  DIGITS  SHALL carry one serial 7-seg bit per lane; lane d carries digit d.
REQ-006: shiftIn  input  1  SHALL be the shift clock; each bit is valid while shiftIn is high.
REQ-007: cnt_out  output  4*DIGITS  SHALL hold the recovered BCD value; digit d is in bits [4d+3:4d].
REQ-008: valid  output  1  SHALL pulse high for one clk when cnt_out updates.
REQ-009: codeErr  output  1  SHALL be high together with valid when any digit of that frame was an illegal pattern.
REQ-010: frameErr  output  1  SHALL pulse high for one clk on a frame timeout or an overrun.

Function
REQ-011: segIn and shiftIn SHALL pass through identical 2-flop synchronizers; a shift edge is a synchronized 0->1 transition.
REQ-012: On each shift edge in RECV, segIn[d] SHALL be stored as bit k of lane d's 8-bit frame register, with k = edge index 0..7 (LSB first).
REQ-013: States: IDLE, RECV, DECODE, DONE; reset state IDLE.
REQ-014: IDLE -> RECV SHALL occur on a shift edge, which captures bit 0 with bit counter = 1.
REQ-015: RECV SHALL go to DECODE on the 8th edge; bit counter SHALL return to 0.
REQ-016: DECODE SHALL convert one digit per clk, starting at digit 0, through a single shared decoder, for DIGITS clks.
REQ-017: DONE SHALL last one clk, load cnt_out, pulse valid, set codeErr for that frame, and return to IDLE.
REQ-018: Latency SHALL be DIGITS+1 clks from the 8th synchronized edge to valid.
REQ-019: Decode table, bit0=a..bit6=g, active high: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F (hex).
REQ-020: Any other 7-bit pattern, or bit7=1, SHALL yield nibble F and mark the frame as a code error.
REQ-021: A shift edge during DECODE or DONE SHALL be dropped, pulse frameErr, and leave the current frame unaffected.
REQ-022: cnt_out SHALL hold its value between valid pulses; valid and codeErr SHALL be 0 outside DONE.

Reset
REQ-023: Reset SHALL immediately clear cnt_out, valid, codeErr, frameErr, all frame registers, bit counter and synchronizers, and force IDLE.
REQ-024: Reset mid-frame SHALL discard the partial frame; the next full frame after release SHALL decode correctly.

Configuration
REQ-025: With SEGCAPTURE_TIMEOUT_EN defined, TIMEOUT consecutive clks in RECV without a shift edge SHALL discard the partial frame, pulse frameErr, and return to IDLE.
REQ-026: With SEGCAPTURE_TIMEOUT_EN undefined, RECV SHALL wait indefinitely, and frameErr SHALL report overrun only.

Verification
REQ-027: DIGITS=6 frame of digits 6,5,4,3,2,1 (lane0=6), sent as 8 low/high shift pulses -> cnt_out=24'h123456, one valid pulse, codeErr=0.
REQ-028: Same frame with lane2 = 0x49 -> cnt_out=24'h123F56, valid=1 with codeErr=1.
REQ-029: TIMEOUT_EN with 3 edges, then 64 idle clks -> one frameErr pulse, no valid; next frame 000000 -> cnt_out=0, valid.
REQ-030: Reset asserted after 4 edges -> all outputs 0 at once; after release, frame 987654 -> cnt_out=24'h987654.
REQ-031: Extra shift edge one clk after the 8th edge -> frameErr pulse; valid follows DIGITS+1 clks after the 8th edge with the correct value.
REQ-032: Two back-to-back frames, 111111 then 222222 -> two valid pulses, cnt_out held at 24'h111111 until the second pulse.
